// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode 7-segment scan controller with 16-level PWM
// brightness and a double-buffered frame loaded over valid/ready.
module seg_scan_ctrl #(
    parameter int NDIG    = 8,
    parameter int SUB_DIV = 781
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4*NDIG-1:0] upd_data,
    input  logic [NDIG-1:0]   upd_dp,
    input  logic [NDIG-1:0]   upd_en,
    input  logic              upd_valid,
    output logic              upd_ready,
    input  logic [3:0]        brightness,
    output logic [NDIG-1:0]   scan_out,
    output logic [7:0]        seg_out,
    output logic              frame_start
);

    localparam int SW = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
    localparam int IW = $clog2(NDIG);
    localparam logic [SW-1:0] SUB_LAST = SW'(SUB_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

    function automatic logic [6:0] hex7(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic [SW-1:0]     sub_cnt_q, sub_cnt_d;
    logic [3:0]        phase_q, phase_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [3:0]        bright_q, bright_d;
    logic              pending_q, pending_d;
    logic [4*NDIG-1:0] sh_data_q, sh_data_d;
    logic [NDIG-1:0]   sh_dp_q, sh_dp_d;
    logic [NDIG-1:0]   sh_en_q, sh_en_d;
    logic [4*NDIG-1:0] act_data_q, act_data_d;
    logic [NDIG-1:0]   act_dp_q, act_dp_d;
    logic [NDIG-1:0]   act_en_q, act_en_d;
    logic [NDIG-1:0]   scan_q, scan_d;
    logic [7:0]        seg_q, seg_d;
    logic              fs_q, fs_d;

    logic       sub_wrap;
    logic       phase_wrap;
    logic       slot_start;
    logic       frame_bound;
    logic       lit;
    logic       xfer;
    logic [3:0] cur_nib;

    always_comb begin
        sub_wrap    = (sub_cnt_q == SUB_LAST);
        phase_wrap  = sub_wrap && (phase_q == 4'd15);
        slot_start  = (sub_cnt_q == '0) && (phase_q == 4'd0);
        frame_bound = slot_start && (idx_q == '0);

        sub_cnt_d = sub_wrap ? '0 : sub_cnt_q + 1'b1;
        phase_d   = sub_wrap ? phase_q + 4'd1 : phase_q;
        idx_d     = idx_q;
        if (phase_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        bright_d = slot_start ? brightness : bright_q;

        // phase 0 is always dark so ghosting from the previous digit dies out
        lit = (phase_q != 4'd0) && (phase_q <= bright_q) && act_en_q[idx_q];
        cur_nib = act_data_q[4*idx_q +: 4];
        scan_d  = lit ? ~(NDIG'(1) << idx_q) : '1;
        seg_d   = lit ? {~act_dp_q[idx_q], hex7(cur_nib)} : 8'hFF;
        fs_d    = frame_bound;

        xfer       = upd_valid && !pending_q;
        pending_d  = pending_q;
        sh_data_d  = sh_data_q;
        sh_dp_d    = sh_dp_q;
        sh_en_d    = sh_en_q;
        act_data_d = act_data_q;
        act_dp_d   = act_dp_q;
        act_en_d   = act_en_q;
        if (frame_bound && pending_q) begin
            act_data_d = sh_data_q;
            act_dp_d   = sh_dp_q;
            act_en_d   = sh_en_q;
            pending_d  = 1'b0;
        end else if (xfer) begin
            sh_data_d = upd_data;
            sh_dp_d   = upd_dp;
            sh_en_d   = upd_en;
            pending_d = 1'b1;
        end
    end

    // enables come out of reset all-on so a fresh display shows zeros
    always_ff @(posedge clk) begin
        if (reset) begin
            sub_cnt_q  <= '0;
            phase_q    <= '0;
            idx_q      <= '0;
            bright_q   <= '0;
            pending_q  <= 1'b0;
            sh_data_q  <= '0;
            sh_dp_q    <= '0;
            sh_en_q    <= '1;
            act_data_q <= '0;
            act_dp_q   <= '0;
            act_en_q   <= '1;
            scan_q     <= '1;
            seg_q      <= 8'hFF;
            fs_q       <= 1'b0;
        end else begin
            sub_cnt_q  <= sub_cnt_d;
            phase_q    <= phase_d;
            idx_q      <= idx_d;
            bright_q   <= bright_d;
            pending_q  <= pending_d;
            sh_data_q  <= sh_data_d;
            sh_dp_q    <= sh_dp_d;
            sh_en_q    <= sh_en_d;
            act_data_q <= act_data_d;
            act_dp_q   <= act_dp_d;
            act_en_q   <= act_en_d;
            scan_q     <= scan_d;
            seg_q      <= seg_d;
            fs_q       <= fs_d;
        end
    end

    assign upd_ready   = ~pending_q;
    assign scan_out    = scan_q;
    assign seg_out     = seg_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: NDIG=4, SUB_DIV=2 (32-cycle slot, 128-cycle frame),
// timeline model plus directed literal checks and random traffic.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] upd_data = '0;
    logic [3:0]  upd_dp = '0;
    logic [3:0]  upd_en = '0;
    logic        upd_valid = 1'b0;
    logic        upd_ready;
    logic [3:0]  brightness = 4'd15;
    logic [3:0]  scan_out;
    logic [7:0]  seg_out;
    logic        frame_start;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    seg_scan_ctrl #(.NDIG(4), .SUB_DIV(2)) dut (
        .clk(clk), .reset(reset),
        .upd_data(upd_data), .upd_dp(upd_dp), .upd_en(upd_en),
        .upd_valid(upd_valid), .upd_ready(upd_ready),
        .brightness(brightness),
        .scan_out(scan_out), .seg_out(seg_out), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // model: position in frame is plain time since reset modulo 128
    logic [6:0] dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    int          m_t;
    int          m_b;
    bit          m_pend;
    logic [15:0] sh_d, ac_d;
    logic [3:0]  sh_p, sh_e, ac_p, ac_e;
    logic [3:0]  exp_scan;
    logic [7:0]  exp_seg;
    logic        exp_fs, exp_rdy;

    always @(posedge clk) begin
        int p, d, ph;
        bit on;
        logic [3:0] nib;
        if (reset) begin
            m_t = 0; m_b = 0; m_pend = 0;
            sh_d = '0; sh_p = '0; sh_e = '1;
            ac_d = '0; ac_p = '0; ac_e = '1;
            exp_scan = 4'hF; exp_seg = 8'hFF; exp_fs = 0; exp_rdy = 1;
        end else begin
            p  = m_t % 128;
            d  = p / 32;
            ph = (p % 32) / 2;
            if (p % 32 == 0) m_b = int'(brightness);
            on  = (ph >= 1) && (ph <= m_b) && ac_e[d];
            nib = ac_d[4*d +: 4];
            exp_scan = on ? (4'hF & ~(4'b0001 << d)) : 4'hF;
            exp_seg  = on ? {~ac_p[d], dec[nib]} : 8'hFF;
            exp_fs   = (p == 0);
            if (p == 0 && m_pend) begin
                ac_d = sh_d; ac_p = sh_p; ac_e = sh_e; m_pend = 0;
            end else if (upd_valid && !m_pend) begin
                sh_d = upd_data; sh_p = upd_dp; sh_e = upd_en; m_pend = 1;
            end
            exp_rdy = !m_pend;
            m_t++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            vectors++;
            if (scan_out !== exp_scan || seg_out !== exp_seg ||
                frame_start !== exp_fs || upd_ready !== exp_rdy) begin
                miscompares++;
                $display("FAIL model t=%0t scan %h/%h seg %h/%h fs %b/%b rdy %b/%b (dut/exp)",
                         $time, scan_out, exp_scan, seg_out, exp_seg,
                         frame_start, exp_fs, upd_ready, exp_rdy);
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic skip(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_fs();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (frame_start === 1'b1) return;
        end
        vectors++;
        miscompares++;
        $display("FAIL wait_fs: no frame_start within 400 cycles");
    endtask

    task automatic offer(input logic [15:0] d, input logic [3:0] p, input logic [3:0] e);
        @(negedge clk);
        upd_data = d; upd_dp = p; upd_en = e; upd_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (upd_ready === 1'b1) begin
                @(negedge clk);
                upd_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        upd_valid = 1'b0;
        vectors++;
        miscompares++;
        $display("FAIL offer: upd_ready never rose within 400 cycles");
    endtask

    task automatic count_lit(output int n);
        n = 0;
        for (int i = 0; i < 128; i++) begin
            if (i > 0) @(negedge clk);
            if (scan_out != 4'hF) n++;
        end
    endtask

    initial begin
        int n;
        logic [3:0] strobes [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [7:0] segs    [4] = '{8'h79, 8'hA4, 8'h8E, 8'h80};

        // reset held 3 cycles, then first slot
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_scan", 16'(scan_out), 16'hF);
        chk("rst_ready", 16'(upd_ready), 16'h1);
        skip(2);
        reset = 1'b0;
        @(negedge clk);
        chk("first_fs", 16'(frame_start), 16'h1);
        chk("first_scan", 16'(scan_out), 16'hF);
        chk("first_seg", 16'(seg_out), 16'hFF);
        skip(2);
        chk("lit_scan", 16'(scan_out), 16'b1110);
        chk("lit_seg", 16'(seg_out), 16'hC0);

        // frame load and per-slot decode
        offer(16'h8F21, 4'b0001, 4'hF);
        chk("ready_pending", 16'(upd_ready), 16'h0);
        wait_fs();
        skip(5);
        for (int d = 0; d < 4; d++) begin
            if (d > 0) skip(32);
            chk($sformatf("slot%0d_scan", d), 16'(scan_out), 16'(strobes[d]));
            chk($sformatf("slot%0d_seg", d), 16'(seg_out), 16'(segs[d]));
        end

        // brightness duty
        brightness = 4'd4;
        wait_fs();
        count_lit(n);
        chk("duty_b4", 16'(n), 16'd32);
        brightness = 4'd0;
        wait_fs();
        count_lit(n);
        chk("duty_b0", 16'(n), 16'd0);
        brightness = 4'd15;

        // two frames offered back to back mid-frame
        wait_fs();
        skip(40);
        offer(16'h0123, 4'b0000, 4'hF);
        chk("ready_after_A", 16'(upd_ready), 16'h0);
        offer(16'h4567, 4'b0000, 4'hF);
        skip(4);
        chk("A_digit0", 16'(seg_out), 16'hB0);
        wait_fs();
        skip(5);
        chk("B_digit0", 16'(seg_out), 16'hF8);

        // enable mask keeps slot timing
        offer(16'h8F21, 4'b0001, 4'b1010);
        wait_fs();
        count_lit(n);
        chk("en_mask_lit", 16'(n), 16'd60);
        @(negedge clk);
        chk("frame_len", 16'(frame_start), 16'h1);

        // reset at digit 2 phase 5 with a frame pending
        wait_fs();
        skip(20);
        upd_data = 16'hFFFF; upd_dp = 4'hF; upd_en = 4'hF; upd_valid = 1'b1;
        @(negedge clk);
        upd_valid = 1'b0;
        chk("pend_before_rst", 16'(upd_ready), 16'h0);
        skip(52);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_scan", 16'(scan_out), 16'hF);
        chk("rst_mid_seg", 16'(seg_out), 16'hFF);
        chk("rst_mid_ready", 16'(upd_ready), 16'h1);
        @(negedge clk);
        reset = 1'b0;
        wait_fs();
        skip(5);
        chk("post_rst_scan", 16'(scan_out), 16'b1110);
        chk("post_rst_seg", 16'(seg_out), 16'hC0);

        // random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            upd_valid = ($urandom_range(0, 7) == 0);
            upd_data  = 16'($urandom);
            upd_dp    = 4'($urandom);
            upd_en    = 4'($urandom);
            if ($urandom_range(0, 99) == 0) brightness = 4'($urandom);
            reset = ($urandom_range(0, 799) == 0);
        end
        @(negedge clk);
        reset = 1'b0;
        upd_valid = 1'b0;
        skip(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
